// File: rtl/asrm_pkg.sv
// Shared asrm constants: request size codes, adapter FSM states and the
// effective-access-size helper used by the width adapter.
package asrm_pkg;

  typedef enum logic [1:0] {
    SZ_FULL = 2'b00,
    SZ_32   = 2'b01,
    SZ_16   = 2'b10,
    SZ_8    = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } state_e;

  // Access size in bytes, clamped to the RAM word so oversize codes mean "full".
  function automatic logic [5:0] eff_bytes(input logic [1:0] size,
                                           input int unsigned word_bytes);
    logic [5:0] nb;
    case (size)
      SZ_32:   nb = 6'd4;
      SZ_16:   nb = 6'd2;
      SZ_8:    nb = 6'd1;
      default: nb = 6'(word_bytes);
    endcase
    if ({26'd0, nb} > word_bytes) nb = 6'(word_bytes);
    return nb;
  endfunction

endpackage

// File: rtl/asrm_mem_width_adapter_lane_merge.sv
// Little-endian lane extract/merge: pulls the addressed lanes of a word down
// to bit 0, and splices the low bytes of data into those lanes.
module asrm_lane_merge #(
  parameter int unsigned WORDSIZE = 16
) (
  input  logic [WORDSIZE-1:0] word,
  input  logic [WORDSIZE-1:0] data,
  input  logic [5:0]          offset,
  input  logic [5:0]          size,
  output logic [WORDSIZE-1:0] extracted,
  output logic [WORDSIZE-1:0] merged
);

  localparam logic [7:0] W_BITS = 8'(WORDSIZE);

  logic [7:0]          lane_sh;
  logic [7:0]          size_bits;
  logic [WORDSIZE-1:0] mask;

  always_comb begin
    lane_sh   = {offset[4:0], 3'b000};
    size_bits = {size[4:0], 3'b000};
    // Shift ones down rather than up so a full-width size never overflows.
    mask      = {WORDSIZE{1'b1}} >> (W_BITS - size_bits);
    extracted = (word >> lane_sh) & mask;
    merged    = (word & ~(mask << lane_sh)) | ((data & mask) << lane_sh);
  end

endmodule

// File: rtl/asrm_mem_width_adapter.sv
// CPU-to-RAM width adapter: sized byte-addressed loads/stores onto a
// word-wide RAM, with read-modify-write for narrow stores.
module asrm_mem_width_adapter
  import asrm_pkg::*;
#(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [WORDSIZE-1:0] rsp_rdata,
  output logic [5:0]          pop_offset,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [WORDSIZE-1:0] ram_wdata,
  input  logic [WORDSIZE-1:0] ram_rdata
);

  localparam int unsigned       WORD_BYTES = WORDSIZE / 8;
  localparam int unsigned       OFFS_W     = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] OFFS_MASK  = ADDR_W'(WORD_BYTES - 1);
  localparam logic [5:0]        FULL_BYTES = 6'(WORD_BYTES);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [5:0]          offs_q, offs_d;
  logic [5:0]          size_q, size_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic [WORDSIZE-1:0] word_q, word_d;
  logic [WORDSIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;

  logic [5:0]          req_bytes;
  logic [5:0]          req_offs;
  logic                req_misaligned;
  logic [WORDSIZE-1:0] lane_word, lane_ext, lane_merged;

  always_comb begin
    req_bytes      = eff_bytes(req_size, WORD_BYTES);
    req_offs       = 6'(req_addr & OFFS_MASK);
    req_misaligned = (req_offs & (req_bytes - 6'd1)) != '0;
    // In CAP the RAM word is live on ram_rdata; afterwards it sits in word_q.
    lane_word      = (state_q == ST_CAP) ? ram_rdata : word_q;
  end

  asrm_lane_merge #(
    .WORDSIZE(WORDSIZE)
  ) u_lane (
    .word     (lane_word),
    .data     (wdata_q),
    .offset   (offs_q),
    .size     (size_q),
    .extracted(lane_ext),
    .merged   (lane_merged)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    err_d       = err_q;
    offs_d      = offs_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rsp_rdata_d = rsp_rdata_q;
    word_addr_d = word_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          err_d       = req_misaligned;
          offs_d      = req_offs;
          size_d      = req_bytes;
          wdata_d     = req_wdata;
          word_addr_d = req_addr >> OFFS_W;
          if (req_misaligned) begin
            state_d     = ST_RESP;
            rsp_rdata_d = '0;
          end else if (req_write && (req_bytes == FULL_BYTES)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        word_d = ram_rdata;
        if (write_q) begin
          state_d = ST_WR;
        end else begin
          state_d     = ST_RESP;
          rsp_rdata_d = lane_ext;
        end
      end
      ST_WR: begin
        state_d     = ST_RESP;
        rsp_rdata_d = '0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      offs_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_rdata_q <= '0;
      word_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      err_q       <= err_d;
      offs_q      <= offs_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rsp_rdata_q <= rsp_rdata_d;
      word_addr_q <= word_addr_d;
    end
  end

  // A full-width store merges under an all-ones mask, so it is just wdata.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_RESP);
    rsp_err    = (state_q == ST_RESP) && err_q;
    rsp_rdata  = rsp_rdata_q;
    pop_offset = req_bytes;
    ram_en     = (state_q == ST_RD) || (state_q == ST_WR);
    ram_we     = (state_q == ST_WR);
    ram_addr   = word_addr_q;
    ram_wdata  = (state_q == ST_WR) ? lane_merged : '0;
  end

endmodule

// File: tb/tb_asrm_mem_width_adapter.sv
// Directed bench for asrm_mem_width_adapter at WORDSIZE=32 with a small
// behavioural RAM; table of transactions plus reset/back-to-back sequences.
module tb_asrm_mem_width_adapter;

  localparam int unsigned WS = 32;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic [WS-1:0] req_wdata;
  logic          req_ready, rsp_valid, rsp_err;
  logic [WS-1:0] rsp_rdata;
  logic [5:0]    pop_offset;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [WS-1:0] ram_wdata;
  logic [WS-1:0] ram_rdata;
  logic          ram_clr;

  logic [WS-1:0] mem [16];
  int unsigned   we_count = 0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  asrm_mem_width_adapter #(.WORDSIZE(WS), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .pop_offset(pop_offset), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr[3:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[3:0]];
    end
    if (ram_we) we_count <= we_count + 1;
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic [WS-1:0] wdata;
    logic [5:0]    pop;
    logic          err;
    int            lat;
    logic [WS-1:0] rdata;
    logic          do_wr;
    int            wr_lat;
    logic [AW-1:0] wr_addr;
    logic [WS-1:0] wr_data;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_txn(input int id, input vec_t v);
    int            lat = 0;
    int            wr_lat = -1;
    int            wr_cnt = 0;
    int            en_cnt = 0;
    logic [AW-1:0] wa = '0;
    logic [WS-1:0] wd = '0;
    req_write = v.wr;
    req_addr  = v.addr;
    req_size  = v.size;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    #1;
    check($sformatf("v%0d pop_offset", id), pop_offset, v.pop);
    check($sformatf("v%0d req_ready", id), req_ready, 1);
    @(posedge clk);
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (ram_en) en_cnt++;
      if (ram_en && ram_we) begin
        wr_cnt++;
        wr_lat = lat;
        wa = ram_addr;
        wd = ram_wdata;
      end
      if (rsp_valid) break;
    end
    check($sformatf("v%0d latency", id), lat, v.lat);
    check($sformatf("v%0d rsp_err", id), rsp_err, v.err);
    check($sformatf("v%0d rsp_rdata", id), rsp_rdata, v.rdata);
    check($sformatf("v%0d ram_write_count", id), wr_cnt, v.do_wr ? 1 : 0);
    if (v.err) check($sformatf("v%0d ram_en_count", id), en_cnt, 0);
    if (v.do_wr) begin
      check($sformatf("v%0d write_latency", id), wr_lat, v.wr_lat);
      check($sformatf("v%0d ram_addr", id), wa, v.wr_addr);
      check($sformatf("v%0d ram_wdata", id), wd, v.wr_data);
    end
    @(negedge clk);
    check($sformatf("v%0d rsp_pulse_end", id), rsp_valid, 0);
    check($sformatf("v%0d ready_after_resp", id), req_ready, 1);
    check($sformatf("v%0d rdata_held", id), rsp_rdata, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned   we_before;
    int            idx;
    int            first_rsp;
    int            second_rsp;
    logic [WS-1:0] first_data;
    logic [WS-1:0] second_data;
    vec_t          v;

    //            wr    addr    sz     wdata          pop err lat rdata         dowr wl waddr  wdata
    vecs[0]  = '{1'b1, 16'h10, 2'b00, 32'hAABBCCDD, 6'd4, 1'b0, 2, 32'h0,        1'b1, 1, 16'h4, 32'hAABBCCDD};
    vecs[1]  = '{1'b1, 16'h12, 2'b11, 32'h00000055, 6'd1, 1'b0, 4, 32'h0,        1'b1, 3, 16'h4, 32'hAA55CCDD};
    vecs[2]  = '{1'b0, 16'h12, 2'b10, 32'h0,        6'd2, 1'b0, 3, 32'h0000AA55, 1'b0, 0, 16'h0, 32'h0};
    vecs[3]  = '{1'b1, 16'h13, 2'b10, 32'h00001234, 6'd2, 1'b1, 1, 32'h0,        1'b0, 0, 16'h0, 32'h0};
    vecs[4]  = '{1'b1, 16'h08, 2'b01, 32'h12345678, 6'd4, 1'b0, 2, 32'h0,        1'b1, 1, 16'h2, 32'h12345678};
    vecs[5]  = '{1'b0, 16'h11, 2'b11, 32'h0,        6'd1, 1'b0, 3, 32'h000000CC, 1'b0, 0, 16'h0, 32'h0};
    vecs[6]  = '{1'b0, 16'h08, 2'b00, 32'h0,        6'd4, 1'b0, 3, 32'h12345678, 1'b0, 0, 16'h0, 32'h0};
    vecs[7]  = '{1'b0, 16'h13, 2'b11, 32'h0,        6'd1, 1'b0, 3, 32'h000000AA, 1'b0, 0, 16'h0, 32'h0};
    vecs[8]  = '{1'b1, 16'h0A, 2'b10, 32'hFFFFBEEF, 6'd2, 1'b0, 4, 32'h0,        1'b1, 3, 16'h2, 32'hBEEF5678};
    vecs[9]  = '{1'b0, 16'h0A, 2'b10, 32'h0,        6'd2, 1'b0, 3, 32'h0000BEEF, 1'b0, 0, 16'h0, 32'h0};
    vecs[10] = '{1'b0, 16'h06, 2'b01, 32'h0,        6'd4, 1'b1, 1, 32'h0,        1'b0, 0, 16'h0, 32'h0};
    vecs[11] = '{1'b1, 16'h02, 2'b00, 32'hDEADBEEF, 6'd4, 1'b1, 1, 32'h0,        1'b0, 0, 16'h0, 32'h0};
    vecs[12] = '{1'b1, 16'h04, 2'b11, 32'hFFFFFF5A, 6'd1, 1'b0, 4, 32'h0,        1'b1, 3, 16'h1, 32'h0000005A};
    vecs[13] = '{1'b0, 16'h04, 2'b00, 32'h0,        6'd4, 1'b0, 3, 32'h0000005A, 1'b0, 0, 16'h0, 32'h0};
    vecs[14] = '{1'b0, 16'h07, 2'b11, 32'h0,        6'd1, 1'b0, 3, 32'h0,        1'b0, 0, 16'h0, 32'h0};

    reset     = 1'b1;
    ram_clr   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = 2'b00;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    ram_clr = 1'b0;

    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset ram_en", ram_en, 0);
    check("reset ram_we", ram_we, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_wdata", ram_wdata, 0);

    for (int i = 0; i < 15; i++) run_txn(i, vecs[i]);

    // Reset during CAP of a narrow store: no RAM write, back to idle.
    we_before = we_count;
    req_write = 1'b1;
    req_addr  = 16'h11;
    req_size  = 2'b11;
    req_wdata = 32'h00000077;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_reset RD ram_en", ram_en, 1);
    check("rmw_reset RD ram_we", ram_we, 0);
    @(negedge clk);
    check("rmw_reset CAP ram_en", ram_en, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rmw_reset req_ready", req_ready, 1);
    check("rmw_reset rsp_valid", rsp_valid, 0);
    check("rmw_reset rsp_rdata", rsp_rdata, 0);
    repeat (3) @(negedge clk);
    check("rmw_reset no_ram_write", we_count - we_before, 0);
    v = '{1'b0, 16'h10, 2'b00, 32'h0, 6'd4, 1'b0, 3, 32'hAA55CCDD, 1'b0, 0, 16'h0, 32'h0};
    run_txn(100, v);

    // req_valid held across two byte loads: responses four cycles apart.
    req_write  = 1'b0;
    req_addr   = 16'h10;
    req_size   = 2'b11;
    req_wdata  = '0;
    req_valid  = 1'b1;
    idx        = 0;
    first_rsp  = 0;
    second_rsp = 0;
    first_data = '0;
    second_data = '0;
    while (idx < 20 && second_rsp == 0) begin
      @(negedge clk);
      idx++;
      if (first_rsp != 0 && idx == first_rsp + 1)
        check("b2b ready_after_resp", req_ready, 1);
      if (rsp_valid) begin
        if (first_rsp == 0) begin
          first_rsp  = idx;
          first_data = rsp_rdata;
        end else begin
          second_rsp  = idx;
          second_data = rsp_rdata;
          req_valid   = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b first_latency", first_rsp, 3);
    check("b2b spacing", second_rsp - first_rsp, 4);
    check("b2b first_rdata", first_data, 32'h000000DD);
    check("b2b second_rdata", second_data, 32'h000000DD);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
